// File: rtl/sc_pkg.sv
// ============================================================================
// sc_pkg : shared types and reconstruction helpers for the SC decoder family
// Revision: 1.0
// ============================================================================
`default_nettype none

package sc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } sc_state_e;

  function automatic int sc_lenbits(input int t);
    return $clog2(t);
  endfunction

  function automatic bit sc_is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Rounded inverse of the SNG mapping: u = round(count * 2^quant / t), q = u - 2^(quant-1).
  function automatic int sc_recon(input int count, input int t, input int quant);
    longint u;
    u = ((longint'(count) << quant) + longint'(t / 2)) >> sc_lenbits(t);
    return int'(u) - (1 << (quant - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/sc_popcount.sv
// ============================================================================
// sc_popcount : combinational binary adder tree counting set bits of iBits
// Revision: 1.0
// ============================================================================
`default_nettype none

module sc_popcount #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]               iBits,
  output logic [$clog2(WIDTH+1)-1:0]     oOnes
);

  localparam int OW     = $clog2(WIDTH + 1);
  localparam int LEVELS = $clog2(WIDTH);
  localparam int NP     = 1 << LEVELS;

  // Heap-ordered tree: node k sums children 2k+1 and 2k+2; leaves padded to a power of two.
  logic [OW-1:0] w_node [2*NP-1];

  for (genvar i = 0; i < NP; i++) begin : g_leaf
    if (i < WIDTH) begin : g_bit
      assign w_node[NP-1+i] = OW'(iBits[i]);
    end else begin : g_pad
      assign w_node[NP-1+i] = '0;
    end
  end

  for (genvar k = 0; k < NP - 1; k++) begin : g_sum
    assign w_node[k] = w_node[2*k+1] + w_node[2*k+2];
  end

  assign oOnes = w_node[0];

endmodule

`default_nettype wire

// File: rtl/sc_decoder.sv
// ============================================================================
// sc_decoder : popcounts a parallel stochastic bitstream LANES bits per cycle
//              and converts the ones-count back to a signed quantised value
// Revision: 1.0
// ============================================================================
`default_nettype none

module sc_decoder
  import sc_pkg::*;
#(
  parameter int BITSTREAM = 64,
  parameter int QUANT     = 8,
  parameter int LANES     = 8
) (
  input  logic                             iClk,
  input  logic                             iRst_n,
  input  logic [BITSTREAM-1:0]             iBitstream,
  input  logic                             iValid,
  output logic                             oReady,
  output logic [QUANT:0]                   oData,
  output logic [$clog2(BITSTREAM+1)-1:0]   oCount,
  output logic                             oValid,
  input  logic                             iReady
);

  localparam int NCHUNK = BITSTREAM / LANES;
  localparam int LENB   = sc_lenbits(BITSTREAM);
  localparam int CNTW   = $clog2(BITSTREAM + 1);
  localparam int POPW   = $clog2(LANES + 1);
  localparam int CHW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int UW     = QUANT + LENB + 2;

  if (!sc_is_pow2(BITSTREAM)) begin : g_bad_bitstream
    $error("sc_decoder: BITSTREAM must be a power of two");
  end
  if (!sc_is_pow2(LANES) || (LANES > BITSTREAM) || ((BITSTREAM % LANES) != 0)) begin : g_bad_lanes
    $error("sc_decoder: LANES must be a power of two dividing BITSTREAM");
  end

  sc_state_e               state_q, state_d;
  logic [BITSTREAM-1:0]    shreg_q, shreg_d;
  logic [CNTW-1:0]         acc_q,   acc_d;
  logic [CHW-1:0]          chunk_q, chunk_d;
  logic [CNTW-1:0]         count_q, count_d;
  logic [QUANT:0]          data_q,  data_d;
  logic                    valid_q, valid_d;

  logic [POPW-1:0]         w_ones;
  logic [UW-1:0]           w_u;
  logic [QUANT:0]          w_data;

  sc_popcount #(
    .WIDTH (LANES)
  ) u_popcount (
    .iBits (shreg_q[LANES-1:0]),
    .oOnes (w_ones)
  );

  // Widened so count == BITSTREAM yields +2^(QUANT-1) without wrapping.
  assign w_u    = ((UW'(acc_q) << QUANT) + UW'(BITSTREAM / 2)) >> LENB;
  assign w_data = (QUANT+1)'(w_u - UW'(2 ** (QUANT - 1)));

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    chunk_d = chunk_q;
    count_d = count_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (iValid) begin
          shreg_d = iBitstream;
          acc_d   = '0;
          chunk_d = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        acc_d   = acc_q + CNTW'(w_ones);
        shreg_d = shreg_q >> LANES;
        chunk_d = chunk_q + CHW'(1);
        if (chunk_q == CHW'(NCHUNK - 1)) begin
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        count_d = acc_q;
        data_d  = w_data;
        valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (iReady) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      acc_q   <= '0;
      chunk_q <= '0;
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      chunk_q <= chunk_d;
      count_q <= count_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign oReady = (state_q == IDLE);
  assign oData  = data_q;
  assign oCount = count_q;
  assign oValid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_sc_decoder.sv
// ============================================================================
// tb_sc_decoder : scoreboard bench for sc_decoder with a SNG-level model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sc_decoder;

  localparam int T   = 64;
  localparam int Q   = 8;
  localparam int L   = 8;
  localparam int CW  = $clog2(T + 1);
  localparam int LAT = T / L + 1;

  logic             iClk = 1'b0;
  logic             iRst_n = 1'b0;
  logic [T-1:0]     iBitstream = '0;
  logic             iValid = 1'b0;
  logic             iReady = 1'b1;
  logic             oReady;
  logic signed [Q:0] oData;
  logic [CW-1:0]    oCount;
  logic             oValid;

  sc_decoder #(
    .BITSTREAM (T),
    .QUANT     (Q),
    .LANES     (L)
  ) dut (
    .iClk       (iClk),
    .iRst_n     (iRst_n),
    .iBitstream (iBitstream),
    .iValid     (iValid),
    .oReady     (oReady),
    .oData      (oData),
    .oCount     (oCount),
    .oValid     (oValid),
    .iReady     (iReady)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    int cnt;
    int dat;
    int acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   mode = 0;       // 0: iReady high, 1: iReady random, 2: iReady low
  bit   have_last = 1'b0;
  int   last_cnt = 0;
  int   last_dat = 0;

  always @(posedge iClk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected decode: rounded count * 2^Q / T, re-centred on zero.
  function automatic int model_data(input int cnt);
    return (cnt * (1 << Q) + T / 2) / T - (1 << (Q - 1));
  endfunction

  // SNG mapping: u = q + 2^(Q-1), s = round(u * T / 2^Q).
  function automatic int sng_count(input int q);
    int u;
    u = q + (1 << (Q - 1));
    return (u * T + (1 << (Q - 1))) / (1 << Q);
  endfunction

  function automatic logic [T-1:0] make_stream(input int ones);
    logic [T-1:0] v;
    v = '0;
    while ($countones(v) < ones) v[$urandom_range(T-1, 0)] = 1'b1;
    return v;
  endfunction

  initial begin
    forever begin
      @(posedge iClk);
      #1;
      case (mode)
        0:       iReady = 1'b1;
        1:       iReady = 1'($urandom_range(1, 0));
        default: iReady = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each result and checks hold/retention behaviour.
  initial begin
    exp_t e;
    bit   prev_v;
    int   vcycles;
    int   rise_mode;
    prev_v = 1'b0;
    vcycles = 0;
    rise_mode = 0;
    forever begin
      @(negedge iClk);
      if (oValid && !prev_v) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("oCount", int'(oCount), e.cnt);
          chk("oData", int'(oData), e.dat);
          chk("latency", cyc - e.acc_cyc, LAT);
        end
        last_cnt  = int'(oCount);
        last_dat  = int'(oData);
        have_last = 1'b1;
        vcycles   = 1;
        rise_mode = mode;
      end else if (oValid) begin
        chk("hold_oData", int'(oData), last_dat);
        chk("hold_oCount", int'(oCount), last_cnt);
        vcycles++;
      end else if (have_last) begin
        chk("retain_oData", int'(oData), last_dat);
        chk("retain_oCount", int'(oCount), last_cnt);
      end
      if (oValid) chk("oReady_busy", int'(oReady), 0);
      if (!oValid && prev_v) begin
        chk("oReady_after_handshake", int'(oReady), 1);
        if (rise_mode == 0) chk("done_one_cycle", vcycles, 1);
      end
      prev_v = oValid;
    end
  end

  task automatic send(input logic [T-1:0] s, input int ecnt, input int edat);
    int n;
    exp_t e;
    n = 0;
    @(negedge iClk);
    while (!oReady && n < 200) begin
      @(negedge iClk);
      n++;
    end
    if (!oReady) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    iBitstream = s;
    iValid = 1'b1;
    @(posedge iClk);
    #1;
    iValid = 1'b0;
    e.cnt = ecnt;
    e.dat = edat;
    e.acc_cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || oValid) && n < 500) begin
      @(negedge iClk);
      n++;
    end
    if (exp_q.size() != 0 || oValid) chk("drain_timeout", 0, 1);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!oValid && n < 50) begin
      @(negedge iClk);
      n++;
    end
    if (!oValid) chk("valid_timeout", 0, 1);
  endtask

  initial begin
    logic [T-1:0] v;
    int s;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    chk("rst_oReady", int'(oReady), 1);
    chk("rst_oValid", int'(oValid), 0);
    chk("rst_oData", int'(oData), 0);
    chk("rst_oCount", int'(oCount), 0);
    iRst_n = 1'b1;

    send('0, 0, -128);
    drain();
    send({T{1'b1}}, 64, 128);
    drain();

    send(make_stream(32), 32, 0);
    send(make_stream(35), 35, 12);
    send(make_stream(0), 0, -128);
    for (int q = -127; q <= 128; q += 17) begin
      s = sng_count(q);
      send(make_stream(s), s, model_data(s));
    end
    s = sng_count(128);
    send(make_stream(s), s, model_data(s));
    drain();

    mode = 1;
    for (int i = 0; i < 30; i++) begin
      v = {$urandom, $urandom};
      case ($urandom_range(3, 0))
        0:       v = v & {$urandom, $urandom};
        1:       v = v | {$urandom, $urandom};
        default: v = v;
      endcase
      send(v, $countones(v), model_data($countones(v)));
    end
    drain();
    mode = 0;
    repeat (2) @(negedge iClk);

    mode = 2;
    send(make_stream(20), 20, model_data(20));
    wait_valid();
    for (int i = 0; i < 20; i++) begin
      @(negedge iClk);
      iValid = 1'b1;
      iBitstream = {$urandom, $urandom};
    end
    @(negedge iClk);
    iValid = 1'b0;
    mode = 0;
    drain();
    send(make_stream(50), 50, model_data(50));
    drain();

    send(make_stream(40), 40, model_data(40));
    repeat (3) @(posedge iClk);
    #1;
    have_last = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    iRst_n = 1'b0;
    @(posedge iClk);
    #1;
    iRst_n = 1'b1;
    @(negedge iClk);
    chk("abort_oValid", int'(oValid), 0);
    chk("abort_oData", int'(oData), 0);
    chk("abort_oCount", int'(oCount), 0);
    chk("abort_oReady", int'(oReady), 1);
    send(make_stream(35), 35, 12);
    drain();

    repeat (3) @(negedge iClk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
